ysyx_22041207_lsu: RTL and testbench

//  Load/store stage directly downstream of the ALU. Takes the ALU result (effective address or

---
 rtl/ysyx_22041207_lsu_pkg.sv | 37 +++
 rtl/ysyx_22041207_lsu_align.sv | 53 +++++
 rtl/ysyx_22041207_lsu.sv | 123 ++++++++++++
 tb/tb_ysyx_22041207_lsu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_22041207_lsu_pkg;

    localparam int XLEN   = 64;
    localparam int MASK_W = XLEN / 8;

    // Operation codes. Code 3 is unused and behaves as LSU_NONE.
    typedef enum logic [1:0] {
        LSU_NONE  = 2'd0,
        LSU_LOAD  = 2'd1,
        LSU_STORE = 2'd2
    } lsu_op_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Byte enables of an access of the given size, before lane shifting.
    function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041207_lsu_align.sv
// Combinational lane logic: misalign detection, store mask/data shift, and
// load data shift plus sign/zero extension.
module ysyx_22041207_lsu_align
    import ysyx_22041207_lsu_pkg::*;
(
    input  logic [1:0]        i_st_size,
    input  logic [2:0]        i_st_off,
    input  logic [XLEN-1:0]   i_st_wdata,
    output logic              o_misalign,
    output logic [MASK_W-1:0] o_wmask,
    output logic [XLEN-1:0]   o_wdata,
    input  logic [1:0]        i_ld_size,
    input  logic [2:0]        i_ld_off,
    input  logic              i_ld_unsign,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_ldata
);

    logic [XLEN-1:0] w_rsh;

    // Natural alignment check: an access must not cross its own size boundary.
    always_comb begin
        o_misalign = 1'b0;
        case (i_st_size)
            SIZE_H:  o_misalign = i_st_off[0];
            SIZE_W:  o_misalign = |i_st_off[1:0];
            SIZE_D:  o_misalign = |i_st_off;
            default: o_misalign = 1'b0;
        endcase
    end

    // Store lanes; only meaningful when aligned, so shifted-out bits never matter.
    always_comb begin
        o_wmask = size_mask(i_st_size) << i_st_off;
        o_wdata = i_st_wdata << {i_st_off, 3'b000};
    end

    assign w_rsh = i_rdata >> {i_ld_off, 3'b000};

    // Pick the addressed bytes and extend; doubleword ignores the unsigned flag.
    always_comb begin
        case (i_ld_size)
            SIZE_B:  o_ldata = i_ld_unsign ? {{(XLEN-8){1'b0}}, w_rsh[7:0]}
                                           : {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
            SIZE_H:  o_ldata = i_ld_unsign ? {{(XLEN-16){1'b0}}, w_rsh[15:0]}
                                           : {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
            SIZE_W:  o_ldata = i_ld_unsign ? {{(XLEN-32){1'b0}}, w_rsh[31:0]}
                                           : {{(XLEN-32){w_rsh[31]}}, w_rsh[31:0]};
            default: o_ldata = w_rsh;
        endcase
    end

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Load/store stage: single-entry FSM that issues one memory access per op
// and presents the result to writeback over valid/ready.
module ysyx_22041207_lsu
    import ysyx_22041207_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic              in_unsign,
    input  logic [XLEN-1:0]   in_res,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic              wb_misalign
);

    lsu_state_e        r_state, w_next;
    logic [2:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsign;

    logic              w_is_mem;
    logic              w_accept;
    logic              w_misalign;
    logic [MASK_W-1:0] w_wmask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ldata;

    assign w_is_mem = (in_op == LSU_LOAD) || (in_op == LSU_STORE);
    assign w_accept = in_valid && in_ready;

    ysyx_22041207_lsu_align u_align (
        .i_st_size   (in_size),
        .i_st_off    (in_res[2:0]),
        .i_st_wdata  (in_wdata),
        .o_misalign  (w_misalign),
        .o_wmask     (w_wmask),
        .o_wdata     (w_wdata),
        .i_ld_size   (r_size),
        .i_ld_off    (r_off),
        .i_ld_unsign (r_unsign),
        .i_rdata     (mem_rdata),
        .o_ldata     (w_ldata)
    );

    // State register; reset drops mem_req/wb_valid without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == ST_IDLE);
        mem_req  = (r_state == ST_MEM);
        wb_valid = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: if (in_valid) w_next = (w_is_mem && !w_misalign) ? ST_MEM : ST_DONE;
            ST_MEM:  if (mem_ack)  w_next = ST_DONE;
            ST_DONE: if (wb_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the op on accept; load data lands on the ack edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_unsign    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_wen      <= 1'b0;
            wb_misalign <= 1'b0;
        end else if (w_accept) begin
            wb_rd <= in_rd;
            if (!w_is_mem) begin
                wb_data     <= in_res;
                wb_wen      <= in_wen;
                wb_misalign <= 1'b0;
            end else if (w_misalign) begin
                // Report the faulting address; never touch memory.
                wb_data     <= in_res;
                wb_wen      <= 1'b0;
                wb_misalign <= 1'b1;
            end else begin
                mem_we      <= (in_op == LSU_STORE);
                mem_addr    <= {in_res[XLEN-1:3], 3'b000};
                mem_wdata   <= w_wdata;
                mem_wmask   <= w_wmask;
                r_off       <= in_res[2:0];
                r_size      <= in_size;
                r_unsign    <= in_unsign;
                wb_data     <= '0;
                wb_wen      <= (in_op == LSU_LOAD) && in_wen;
                wb_misalign <= 1'b0;
            end
        end else if ((r_state == ST_MEM) && mem_ack && !mem_we) begin
            wb_data <= w_ldata;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Directed bench: a vector table of single ops plus hand sequences for
// reset, writeback back-pressure and reset during an outstanding access.
module tb_ysyx_22041207_lsu;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op, in_size;
    logic        in_unsign;
    logic [63:0] in_res, in_wdata;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen, wb_misalign;

    int n_run  = 0;
    int n_fail = 0;

    ysyx_22041207_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_unsign(in_unsign), .in_res(in_res), .in_wdata(in_wdata), .in_rd(in_rd),
        .in_wen(in_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_wen(wb_wen), .wb_misalign(wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] res;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        wen;
        int          delay;     // cycles mem_req is high before the ack cycle
        logic [63:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [63:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic [63:0] e_data;
        logic        e_wen;
        logic        e_mis;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                input logic [63:0] res, input logic [63:0] wdata,
                                input logic [4:0] rd, input logic wen, input int delay,
                                input logic [63:0] rdata, input logic e_req, input logic e_we,
                                input logic [63:0] e_addr, input logic [7:0] e_mask,
                                input logic [63:0] e_wdata, input logic [63:0] e_data,
                                input logic e_wen, input logic e_mis);
        vec_t v;
        v.op = op; v.size = size; v.uns = uns; v.res = res; v.wdata = wdata;
        v.rd = rd; v.wen = wen; v.delay = delay; v.rdata = rdata;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_mask = e_mask;
        v.e_wdata = e_wdata; v.e_data = e_data; v.e_wen = e_wen; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                            input logic [63:0] res, input logic [63:0] wdata,
                            input logic [4:0] rd, input logic wen);
        in_valid = 1'b1; in_op = op; in_size = size; in_unsign = uns;
        in_res = res; in_wdata = wdata; in_rd = rd; in_wen = wen;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'd0; in_res = 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        string p;
        v = vecs[i];
        p = $sformatf("v%0d", i);
        check({p, ".in_ready"}, in_ready, 1);
        drive_op(v.op, v.size, v.uns, v.res, v.wdata, v.rd, v.wen);
        check({p, ".mem_req"}, mem_req, v.e_req);
        if (v.e_req) begin
            check({p, ".mem_we"},    mem_we,    v.e_we);
            check({p, ".mem_addr"},  mem_addr,  v.e_addr);
            check({p, ".mem_wmask"}, mem_wmask, v.e_mask);
            if (v.e_we) check({p, ".mem_wdata"}, mem_wdata, v.e_wdata);
            for (int c = 0; c < v.delay; c++) begin
                mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;   // no ack: must be ignored
                @(posedge clk); #1;
                check({p, ".req_hold"},  mem_req,  1);
                check({p, ".addr_hold"}, mem_addr, v.e_addr);
                check({p, ".no_wb"},     wb_valid, 0);
            end
            mem_ack = 1'b1; mem_rdata = v.rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 64'h0;
            check({p, ".req_drop"}, mem_req, 0);
        end
        check({p, ".wb_valid"},    wb_valid,    1);
        check({p, ".wb_data"},     wb_data,     v.e_data);
        check({p, ".wb_rd"},       wb_rd,       v.rd);
        check({p, ".wb_wen"},      wb_wen,      v.e_wen);
        check({p, ".wb_misalign"}, wb_misalign, v.e_mis);
        @(posedge clk); #1;
        check({p, ".bubble"}, wb_valid, 0);
    endtask

    initial begin
        // op: 0 NONE 1 LOAD 2 STORE 3 illegal; size: 0 B 1 H 2 W 3 D
        vecs[0]  = mk(2'd0, 2'd3, 0, 64'h1234, 64'h0, 5'd5, 1, 0, 64'h0,
                      0, 0, 64'h0, 8'h00, 64'h0, 64'h1234, 1, 0);
        vecs[1]  = mk(2'd2, 2'd0, 0, 64'h8000_0003, 64'hAB, 5'd6, 1, 3, 64'h0,
                      1, 1, 64'h8000_0000, 8'h08, 64'hAB00_0000, 64'h0, 0, 0);
        vecs[2]  = mk(2'd1, 2'd1, 0, 64'h8000_0006, 64'h0, 5'd10, 1, 0, 64'h8001_0000_0000_0000,
                      1, 0, 64'h8000_0000, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1, 0);
        vecs[3]  = mk(2'd1, 2'd1, 1, 64'h8000_0006, 64'h0, 5'd11, 1, 1, 64'h8001_0000_0000_0000,
                      1, 0, 64'h8000_0000, 8'hC0, 64'h0, 64'h8001, 1, 0);
        vecs[4]  = mk(2'd1, 2'd2, 0, 64'h8000_0002, 64'h0, 5'd12, 1, 0, 64'h0,
                      0, 0, 64'h0, 8'h00, 64'h0, 64'h8000_0002, 0, 1);
        vecs[5]  = mk(2'd2, 2'd3, 0, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd0, 0, 1, 64'h0,
                      1, 1, 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 0);
        vecs[6]  = mk(2'd1, 2'd0, 0, 64'h8000_0005, 64'h0, 5'd13, 1, 2, 64'h0000_8500_0000_0000,
                      1, 0, 64'h8000_0000, 8'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FF85, 1, 0);
        vecs[7]  = mk(2'd1, 2'd2, 1, 64'h8000_0004, 64'h0, 5'd14, 1, 0, 64'hDEAD_BEEF_0000_0000,
                      1, 0, 64'h8000_0000, 8'hF0, 64'h0, 64'hDEAD_BEEF, 1, 0);
        vecs[8]  = mk(2'd1, 2'd2, 0, 64'h8000_0004, 64'h0, 5'd15, 1, 0, 64'hDEAD_BEEF_0000_0000,
                      1, 0, 64'h8000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1, 0);
        vecs[9]  = mk(2'd1, 2'd3, 1, 64'h8000_0010, 64'h0, 5'd16, 1, 0, 64'h8000_0000_0000_0001,
                      1, 0, 64'h8000_0010, 8'hFF, 64'h0, 64'h8000_0000_0000_0001, 1, 0);
        vecs[10] = mk(2'd2, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 5'd17, 1, 0, 64'h0,
                      1, 1, 64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 0, 0);
        vecs[11] = mk(2'd3, 2'd0, 0, 64'h55, 64'h0, 5'd18, 1, 0, 64'h0,
                      0, 0, 64'h0, 8'h00, 64'h0, 64'h55, 1, 0);
        vecs[12] = mk(2'd2, 2'd3, 0, 64'h8000_0004, 64'h77, 5'd19, 1, 0, 64'h0,
                      0, 0, 64'h0, 8'h00, 64'h0, 64'h8000_0004, 0, 1);
        vecs[13] = mk(2'd2, 2'd2, 0, 64'h8000_0004, 64'hFFFF_FFFF_1234_5678, 5'd20, 1, 2, 64'h0,
                      1, 1, 64'h8000_0000, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 0, 0);

        // Reset held while EX offers a packet.
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd1; in_size = 2'd3; in_unsign = 1'b0;
        in_res = 64'h8000_0000; in_wdata = 64'h0; in_rd = 5'd1; in_wen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",    in_ready,    1);
        check("rst.mem_req",     mem_req,     0);
        check("rst.mem_we",      mem_we,      0);
        check("rst.mem_wmask",   mem_wmask,   0);
        check("rst.mem_addr",    mem_addr,    0);
        check("rst.wb_valid",    wb_valid,    0);
        check("rst.wb_wen",      wb_wen,      0);
        check("rst.wb_misalign", wb_misalign, 0);
        check("rst.wb_data",     wb_data,     0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.in_ready", in_ready, 1);
        check("rel.mem_req",  mem_req,  0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Writeback back-pressure: packet must hold for 4 cycles.
        wb_ready = 1'b0;
        drive_op(2'd0, 2'd0, 0, 64'hCAFE, 64'h0, 5'd7, 1);
        for (int c = 0; c < 4; c++) begin
            check("stall.wb_valid", wb_valid, 1);
            check("stall.wb_data",  wb_data,  64'hCAFE);
            check("stall.wb_rd",    wb_rd,    7);
            check("stall.in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        check("stall.still", wb_valid, 1);
        @(posedge clk); #1;
        check("stall.release", wb_valid, 0);
        check("stall.ready",   in_ready, 1);

        // Async reset with a request outstanding, then a stray ack.
        drive_op(2'd1, 2'd3, 0, 64'h8000_0020, 64'h0, 5'd9, 1);
        check("arst.req_up", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.req_drop", mem_req,  0);
        check("arst.ready",    in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray.wb_valid", wb_valid, 0);
        check("stray.mem_req",  mem_req,  0);
        check("stray.wb_data",  wb_data,  0);
        check("stray.ready",    in_ready, 1);

        // Normal operation resumes after the abandoned access.
        run_vec(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
